// File: rtl/jtframe_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard command sequencer:
// FSM state encoding and the protocol byte constants.
package jtframe_kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_CMD  = 3'd1,
        ST_WAIT_ACK1 = 3'd2,
        ST_SEND_ARG  = 3'd3,
        ST_WAIT_ACK2 = 3'd4
    } kbd_state_t;

    localparam logic [7:0] KBD_CMD_LED  = 8'hED;
    localparam logic [7:0] KBD_CMD_RATE = 8'hF3;
    localparam logic [7:0] KBD_ACK      = 8'hFA;
    localparam logic [7:0] KBD_RESEND   = 8'hFE;

    function automatic logic kbd_is_reply(input logic [7:0] b);
        return (b == KBD_ACK) || (b == KBD_RESEND);
    endfunction

endpackage

// File: rtl/jtframe_kbd_tmo.sv
// Reply timeout counter for the command sequencer WAIT states.
// Cleared on WAIT entry, counts while enabled, flags TIMEOUT-1 reached.
module jtframe_kbd_tmo #(
    parameter logic [23:0] TIMEOUT = 24'd600000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [23:0] LIMIT = TIMEOUT - 24'd1;

    logic [23:0] cnt_q;
    logic [23:0] cnt_d;
    logic        at_limit;

    // Holding at the limit keeps the flag set instead of wrapping around.
    assign at_limit  = (cnt_q >= LIMIT);
    assign expired_o = en_i && at_limit;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 24'd0;
        end else if (en_i && !at_limit) begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jtframe_kbd_cmdseq.sv
// PS/2 keyboard command sequencer: sends LED / typematic commands with ACK,
// resend and timeout retries, and forwards non-reply bytes as key scans.
// Define JTFRAME_KBD_TYPEMATIC_EN to enable the typematic-rate (F3) requester.
module jtframe_kbd_cmdseq
    import jtframe_kbd_pkg::*;
#(
    parameter logic [23:0] TIMEOUT  = 24'd600000,
    parameter int          MAXRETRY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       led_req,
    input  logic [2:0] led_val,
    input  logic       rate_req,
    input  logic [7:0] rate_val,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] key_data,
    output logic       key_valid,
    output logic       busy,
    output logic       cmd_err
);

`ifdef JTFRAME_KBD_TYPEMATIC_EN
    localparam logic RATE_EN = 1'b1;
`else
    localparam logic RATE_EN = 1'b0;
`endif

    localparam logic [7:0] MAXR = 8'(MAXRETRY);

    kbd_state_t state_q, state_d;
    logic       led_pend_q, led_pend_d;
    logic [2:0] led_val_q, led_val_d;
    logic       rate_pend_q, rate_pend_d;
    logic [7:0] rate_val_q, rate_val_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] arg_q, arg_d;
    logic [7:0] retry_q, retry_d;
    logic       err_q, err_d;
    logic [7:0] key_data_q, key_data_d;
    logic       key_vld_q, key_vld_d;

    logic rate_go;
    logic in_wait;
    logic got_ack;
    logic need_retry;
    logic tmo_clr;
    logic tmo_en;
    logic tmo_expired;

    jtframe_kbd_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    assign rate_go    = RATE_EN && rate_req;
    assign in_wait    = (state_q == ST_WAIT_ACK1) || (state_q == ST_WAIT_ACK2);
    assign got_ack    = rx_valid && (rx_data == KBD_ACK);
    // Any received byte masks a coincident timeout for that cycle.
    assign need_retry = (rx_valid && (rx_data == KBD_RESEND)) || (!rx_valid && tmo_expired);

    always_comb begin
        state_d     = state_q;
        led_pend_d  = led_pend_q;
        led_val_d   = led_val_q;
        rate_pend_d = rate_pend_q;
        rate_val_d  = rate_val_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        retry_d     = retry_q;
        err_d       = 1'b0;
        key_data_d  = key_data_q;
        key_vld_d   = 1'b0;
        tmo_clr     = 1'b0;
        tmo_en      = 1'b0;

        if (led_req) begin
            led_pend_d = 1'b1;
            led_val_d  = led_val;
        end
        if (rate_go) begin
            rate_pend_d = 1'b1;
            rate_val_d  = rate_val;
        end

        case (state_q)
            ST_IDLE: begin
                // Argument is frozen at grant so a new request cannot alter the one in flight.
                if (led_pend_q) begin
                    state_d    = ST_SEND_CMD;
                    cmd_d      = KBD_CMD_LED;
                    arg_d      = {5'b0, led_val_q};
                    led_pend_d = led_req;
                    retry_d    = 8'd0;
                end else if (rate_pend_q) begin
                    state_d     = ST_SEND_CMD;
                    cmd_d       = KBD_CMD_RATE;
                    arg_d       = rate_val_q;
                    rate_pend_d = rate_go;
                    retry_d     = 8'd0;
                end
            end
            ST_SEND_CMD: begin
                if (tx_ready) begin
                    state_d = ST_WAIT_ACK1;
                    tmo_clr = 1'b1;
                end
            end
            ST_WAIT_ACK1: begin
                tmo_en = 1'b1;
                if (got_ack) begin
                    state_d = ST_SEND_ARG;
                    retry_d = 8'd0;
                end else if (need_retry) begin
                    if (retry_q == MAXR) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        retry_d = retry_q + 8'd1;
                        state_d = ST_SEND_CMD;
                    end
                end
            end
            ST_SEND_ARG: begin
                if (tx_ready) begin
                    state_d = ST_WAIT_ACK2;
                    tmo_clr = 1'b1;
                end
            end
            ST_WAIT_ACK2: begin
                tmo_en = 1'b1;
                if (got_ack) begin
                    state_d = ST_IDLE;
                end else if (need_retry) begin
                    if (retry_q == MAXR) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        retry_d = retry_q + 8'd1;
                        state_d = ST_SEND_ARG;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // ACK/RESEND are consumed only while a reply is awaited.
        if (rx_valid && !(in_wait && kbd_is_reply(rx_data))) begin
            key_vld_d  = 1'b1;
            key_data_d = rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            led_pend_q  <= 1'b0;
            led_val_q   <= 3'd0;
            rate_pend_q <= 1'b0;
            rate_val_q  <= 8'd0;
            cmd_q       <= 8'd0;
            arg_q       <= 8'd0;
            retry_q     <= 8'd0;
            err_q       <= 1'b0;
            key_data_q  <= 8'd0;
            key_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            led_pend_q  <= led_pend_d;
            led_val_q   <= led_val_d;
            rate_pend_q <= rate_pend_d;
            rate_val_q  <= rate_val_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            retry_q     <= retry_d;
            err_q       <= err_d;
            key_data_q  <= key_data_d;
            key_vld_q   <= key_vld_d;
        end
    end

    assign tx_valid  = (state_q == ST_SEND_CMD) || (state_q == ST_SEND_ARG);
    assign tx_data   = (state_q == ST_SEND_CMD) ? cmd_q :
                       (state_q == ST_SEND_ARG) ? arg_q : 8'd0;
    assign busy      = (state_q != ST_IDLE);
    assign cmd_err   = err_q;
    assign key_data  = key_data_q;
    assign key_valid = key_vld_q;

endmodule

// File: tb/tb_jtframe_kbd_cmdseq.sv
// Directed self-checking bench for jtframe_kbd_cmdseq (TIMEOUT=100, MAXRETRY=2).
module tb_jtframe_kbd_cmdseq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       led_req = 1'b0;
    logic [2:0] led_val = 3'd0;
    logic       rate_req = 1'b0;
    logic [7:0] rate_val = 8'd0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic [7:0] key_data;
    logic       key_valid;
    logic       busy;
    logic       cmd_err;

    int n_assert = 0;
    int n_fail   = 0;
    int tx_total = 0;
    int key_total = 0;
    int err_total = 0;
    int cyc = 0;

    jtframe_kbd_cmdseq #(
        .TIMEOUT  (24'd100),
        .MAXRETRY (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .led_req   (led_req),
        .led_val   (led_val),
        .rate_req  (rate_req),
        .rate_val  (rate_val),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .key_data  (key_data),
        .key_valid (key_valid),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) tx_total <= tx_total + 1;
        if (key_valid) key_total <= key_total + 1;
        if (cmd_err) err_total <= err_total + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_led(input logic [2:0] v);
        led_val = v;
        led_req = 1'b1;
        tick();
        led_req = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = 8'h00;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                b  = tx_data;
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset;
        #12;
        n_assert++;
        if ({tx_valid, busy, cmd_err, key_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, want 0000", {tx_valid, busy, cmd_err, key_valid});
        end
        n_assert++;
        if (tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_tx_data: got %h, want 00", tx_data);
        end
        n_assert++;
        if (key_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_key_data: got %h, want 00", key_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_assert++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b tx_valid=%b, want 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_led;
        logic [7:0] b;
        bit ok;
        int t0, e0;
        t0 = tx_total;
        e0 = err_total;
        pulse_led(3'b101);
        wait_tx(b, ok);
        n_assert++;
        if (!ok || b !== 8'hED) begin
            n_fail++;
            $display("FAIL led_cmd: got %h ok=%0d, want ED", b, ok);
        end
        n_assert++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL led_busy: got %b, want 1", busy);
        end
        send_rx(8'hFA);
        wait_tx(b, ok);
        n_assert++;
        if (!ok || b !== 8'h05) begin
            n_fail++;
            $display("FAIL led_arg: got %h ok=%0d, want 05", b, ok);
        end
        send_rx(8'hFA);
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL led_done_busy: got %b, want 0", busy);
        end
        tick();
        n_assert++;
        if (err_total != e0 || tx_total - t0 != 2) begin
            n_fail++;
            $display("FAIL led_counts: err=%0d tx=%0d, want 0 2", err_total - e0, tx_total - t0);
        end
    endtask

    task automatic test_fe_retry;
        logic [7:0] b;
        bit ok;
        int t0, e0;
        t0 = tx_total;
        e0 = err_total;
        pulse_led(3'b101);
        wait_tx(b, ok);
        n_assert++;
        if (!ok || b !== 8'hED) begin
            n_fail++;
            $display("FAIL fe_first_cmd: got %h ok=%0d, want ED", b, ok);
        end
        send_rx(8'hFE);
        wait_tx(b, ok);
        n_assert++;
        if (!ok || b !== 8'hED) begin
            n_fail++;
            $display("FAIL fe_resent_cmd: got %h ok=%0d, want ED", b, ok);
        end
        send_rx(8'hFA);
        wait_tx(b, ok);
        n_assert++;
        if (!ok || b !== 8'h05) begin
            n_fail++;
            $display("FAIL fe_arg: got %h ok=%0d, want 05", b, ok);
        end
        send_rx(8'hFA);
        tick();
        n_assert++;
        if (busy !== 1'b0 || err_total != e0 || tx_total - t0 != 3) begin
            n_fail++;
            $display("FAIL fe_done: busy=%b err=%0d tx=%0d, want 0 0 3", busy, err_total - e0, tx_total - t0);
        end
    endtask

    task automatic test_timeout;
        logic [7:0] b;
        bit ok;
        bit found;
        int c0, c_err, e0, t3;
        c0 = cyc;
        e0 = err_total;
        c_err = 0;
        pulse_led(3'b101);
        for (int k = 0; k < 3; k++) begin
            wait_tx(b, ok);
            n_assert++;
            if (!ok || b !== 8'hED) begin
                n_fail++;
                $display("FAIL tmo_cmd_%0d: got %h ok=%0d, want ED", k, b, ok);
            end
        end
        t3 = tx_total;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cmd_err) begin
                found = 1'b1;
                c_err = cyc;
                break;
            end
        end
        n_assert++;
        if (!found || (c_err - c0) < 295 || (c_err - c0) > 315) begin
            n_fail++;
            $display("FAIL tmo_err_time: found=%0d cycles=%0d, want 295..315", found, c_err - c0);
        end
        @(negedge clk);
        n_assert++;
        if (cmd_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_err_pulse: cmd_err=%b busy=%b, want 0 0", cmd_err, busy);
        end
        repeat (150) tick();
        n_assert++;
        if (tx_total != t3 || err_total != e0 + 1) begin
            n_fail++;
            $display("FAIL tmo_after: extra_tx=%0d errs=%0d, want 0 1", tx_total - t3, err_total - e0);
        end
    endtask

    task automatic test_both;
        logic [7:0] b;
        bit ok;
        int t0;
        t0 = tx_total;
        led_val  = 3'b011;
        rate_val = 8'h20;
        led_req  = 1'b1;
        rate_req = 1'b1;
        tick();
        led_req  = 1'b0;
        rate_req = 1'b0;
        wait_tx(b, ok);
        n_assert++;
        if (!ok || b !== 8'hED) begin
            n_fail++;
            $display("FAIL both_led_cmd: got %h ok=%0d, want ED", b, ok);
        end
        send_rx(8'hFA);
        wait_tx(b, ok);
        n_assert++;
        if (!ok || b !== 8'h03) begin
            n_fail++;
            $display("FAIL both_led_arg: got %h ok=%0d, want 03", b, ok);
        end
        send_rx(8'hFA);
`ifdef JTFRAME_KBD_TYPEMATIC_EN
        wait_tx(b, ok);
        n_assert++;
        if (!ok || b !== 8'hF3) begin
            n_fail++;
            $display("FAIL both_rate_cmd: got %h ok=%0d, want F3", b, ok);
        end
        send_rx(8'hFA);
        wait_tx(b, ok);
        n_assert++;
        if (!ok || b !== 8'h20) begin
            n_fail++;
            $display("FAIL both_rate_arg: got %h ok=%0d, want 20", b, ok);
        end
        send_rx(8'hFA);
        tick();
        n_assert++;
        if (busy !== 1'b0 || tx_total - t0 != 4) begin
            n_fail++;
            $display("FAIL both_done: busy=%b tx=%0d, want 0 4", busy, tx_total - t0);
        end
`else
        repeat (50) tick();
        n_assert++;
        if (busy !== 1'b0 || tx_total - t0 != 2) begin
            n_fail++;
            $display("FAIL both_no_rate: busy=%b tx=%0d, want 0 2", busy, tx_total - t0);
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [7:0] b;
        bit ok;
        pulse_led(3'b001);
        wait_tx(b, ok);
        n_assert++;
        if (!ok || b !== 8'hED) begin
            n_fail++;
            $display("FAIL b2b_cmd1: got %h ok=%0d, want ED", b, ok);
        end
        pulse_led(3'b110);
        send_rx(8'hFA);
        wait_tx(b, ok);
        n_assert++;
        if (!ok || b !== 8'h01) begin
            n_fail++;
            $display("FAIL b2b_arg1: got %h ok=%0d, want 01", b, ok);
        end
        send_rx(8'hFA);
        wait_tx(b, ok);
        n_assert++;
        if (!ok || b !== 8'hED) begin
            n_fail++;
            $display("FAIL b2b_cmd2: got %h ok=%0d, want ED", b, ok);
        end
        send_rx(8'hFA);
        wait_tx(b, ok);
        n_assert++;
        if (!ok || b !== 8'h06) begin
            n_fail++;
            $display("FAIL b2b_arg2: got %h ok=%0d, want 06", b, ok);
        end
        send_rx(8'hFA);
        tick();
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_busy: got %b, want 0", busy);
        end
    endtask

    task automatic test_forward;
        logic [7:0] b;
        bit ok;
        int k0;
        pulse_led(3'b101);
        wait_tx(b, ok);
        n_assert++;
        if (!ok || b !== 8'hED) begin
            n_fail++;
            $display("FAIL fwd_cmd: got %h ok=%0d, want ED", b, ok);
        end
        k0 = key_total;
        send_rx(8'h1C);
        n_assert++;
        if (key_valid !== 1'b1 || key_data !== 8'h1C) begin
            n_fail++;
            $display("FAIL fwd_scan: valid=%b data=%h, want 1 1C", key_valid, key_data);
        end
        send_rx(8'hFA);
        n_assert++;
        if (key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_ack_consumed: valid=%b, want 0", key_valid);
        end
        wait_tx(b, ok);
        n_assert++;
        if (!ok || b !== 8'h05) begin
            n_fail++;
            $display("FAIL fwd_arg: got %h ok=%0d, want 05", b, ok);
        end
        send_rx(8'hFA);
        tick();
        send_rx(8'hFA);
        n_assert++;
        if (key_valid !== 1'b1 || key_data !== 8'hFA) begin
            n_fail++;
            $display("FAIL fwd_idle_fa: valid=%b data=%h, want 1 FA", key_valid, key_data);
        end
        tick();
        n_assert++;
        if (key_total - k0 != 2) begin
            n_fail++;
            $display("FAIL fwd_count: got %0d pulses, want 2", key_total - k0);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        bit ok;
        int t0, e0;
        pulse_led(3'b101);
        wait_tx(b, ok);
        send_rx(8'hFA);
        wait_tx(b, ok);
        n_assert++;
        if (!ok || b !== 8'h05 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_in_ack2: got %h ok=%0d busy=%b, want 05 1 1", b, ok, busy);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_assert++;
        if ({tx_valid, busy, cmd_err, key_valid} !== 4'b0000 || tx_data !== 8'h00 || key_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_outputs: ctrl=%b tx=%h key=%h, want 0000 00 00",
                     {tx_valid, busy, cmd_err, key_valid}, tx_data, key_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        t0 = tx_total;
        e0 = err_total;
        repeat (60) tick();
        n_assert++;
        if (tx_total != t0 || err_total != e0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: tx=%0d err=%0d busy=%b, want 0 0 0", tx_total - t0, err_total - e0, busy);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_led();
        test_fe_retry();
        test_timeout();
        test_both();
        test_back_to_back();
        test_forward();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/jtframe_kbd_cmdseq.md
JTFRAME_KBD_CMDSEQ -- requirements
Module: jtframe_kbd_cmdseq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 24'd600000; clk cycles to wait for a keyboard reply before a retry.
REQ-002 SHALL have parameter MAXRETRY, default 2; retries allowed per byte before the command is abandoned.
REQ-003 SHALL have port clk  in  1; the single clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1; reset, asynchronous assertion, active-low.
REQ-005 SHALL have ports led_req  in  1 (one-cycle pulse, request LED update) and led_val  in  3 ({caps,num,scroll}).
REQ-006 SHALL have ports rate_req  in  1 (one-cycle pulse, request typematic set) and rate_val  in  8 (typematic argument byte).
REQ-007 SHALL have ports tx_data  out  8, tx_valid  out  1, tx_ready  in  1; byte handshake to the PS/2 host transmitter.
REQ-008 SHALL have ports rx_data  in  8 and rx_valid  in  1; bytes from the PS/2 receiver, valid for one cycle.
REQ-009 SHALL have ports key_data  out  8 and key_valid  out  1; scan bytes forwarded to the key decoder, one-cycle pulse.
REQ-010 SHALL have ports busy  out  1 (command in flight) and cmd_err  out  1 (one-cycle pulse, command abandoned).

Function
REQ-011 SHALL latch each request into a pending flag plus value register; a repeat request while pending overwrites the value (last wins).
REQ-012 SHALL, when a request arrives for the command currently in flight, set its pending flag again so it reruns after completion.
REQ-013 SHALL arbitrate in IDLE with fixed priority LED over rate; the grant clears that pending flag in the same cycle.
REQ-014 SHALL use states IDLE, SEND_CMD, WAIT_ACK1, SEND_ARG, WAIT_ACK2; IDLE->SEND_CMD on grant.
REQ-015 SHALL drive the command byte (8'hED for LED, 8'hF3 for rate) in SEND_CMD and the argument ({5'b0,led_val} or rate_val as latched) in SEND_ARG.
REQ-016 SHALL hold tx_valid high and tx_data stable until the cycle tx_ready is high; SEND_x->WAIT_x on that cycle.
REQ-017 SHALL clear the timeout counter on entry to each WAIT state and increment it every cycle there.
REQ-018 SHALL, in WAIT states, treat rx byte 8'hFA as ACK: WAIT_ACK1->SEND_ARG, WAIT_ACK2->IDLE.
REQ-019 SHALL, in WAIT states, treat 8'hFE or a counter reaching TIMEOUT-1 as a retry: return to the matching SEND state with the same byte and increment the retry count.
REQ-020 SHALL, when a retry is needed and retry count equals MAXRETRY, pulse cmd_err one cycle and go to IDLE, dropping the command.
REQ-021 SHALL reset the retry count on each transition into a SEND state from IDLE or after an ACK.
REQ-022 SHALL give rx_valid priority over timeout when both occur in the same cycle.
REQ-023 SHALL forward every rx byte except FA/FE consumed in WAIT states to key_data/key_valid with exactly one cycle latency.
REQ-024 SHALL drive busy high in every state except IDLE.

Reset
REQ-025 SHALL, on rst_n low, asynchronously enter IDLE and clear pending flags, counters, tx_valid, key_valid, cmd_err, busy, tx_data and key_data to 0.
REQ-026 SHALL, on reset mid-command, abandon it without cmd_err; no byte resent after release.

Configuration
REQ-027 SHALL, with JTFRAME_KBD_TYPEMATIC_EN defined, implement the rate requester as above.
REQ-028 SHALL, without JTFRAME_KBD_TYPEMATIC_EN, ignore rate_req/rate_val (ports kept) and never issue 8'hF3.

Structure
REQ-029 SHALL take the state enum and byte constants (ED, F3, FA, FE) from shared package jtframe_kbd_pkg.
REQ-030 SHALL place the WAIT-state timeout counter in sub-module jtframe_kbd_tmo (clear, enable, expired).

Verification
REQ-031 SHALL cover: led_req with led_val=3'b101, tx_ready always 1, FA after each byte -> tx bytes ED then 05, busy falls, no cmd_err.
REQ-032 SHALL cover: FE reply to ED once -> ED sent twice, then 05, completes normally.
REQ-033 SHALL cover: no reply, TIMEOUT=100, MAXRETRY=2 -> ED sent 3 times, cmd_err pulse ~300 cycles after start, busy low.
REQ-034 SHALL cover: led_req and rate_req (rate_val=8'h20) same cycle -> ED,xx sequence then F3,20 (F3 absent without macro).
REQ-035 SHALL cover: rx bytes 1C, FA while WAIT_ACK1 -> key_data 1C pulsed once, FA consumed; FA in IDLE forwarded.
REQ-036 SHALL cover: rst_n low during WAIT_ACK2 -> all outputs 0 immediately, IDLE after release, no further tx.
